// File: rtl/entity_physics_pkg.sv
// rtl/entity_physics_pkg.sv - shared phase encoding, collision bit indices and packed state layout
package physics_pkg;

  typedef enum logic [1:0] {
    PH_GROUND = 2'd0,
    PH_RISE   = 2'd1,
    PH_FALL   = 2'd2
  } phase_t;

  localparam int COL_LEFT  = 0;
  localparam int COL_BOT   = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_TOP   = 3;

  // Packed state is {x, y, xSpeed, ySpeed, xDir, yDir}, LSB first from yDir.
  localparam int OFF_YDIR = 0;
  localparam int OFF_XDIR = 1;
  localparam int OFF_YSPD = 2;

  function automatic int off_xspd(int spd_w);
    return OFF_YSPD + spd_w;
  endfunction

  function automatic int off_y(int spd_w);
    return OFF_YSPD + 2 * spd_w;
  endfunction

  function automatic int off_x(int pos_w, int spd_w);
    return off_y(spd_w) + pos_w;
  endfunction

  function automatic int state_w(int pos_w, int spd_w);
    return 2 * pos_w + 2 * spd_w + 2;
  endfunction

endpackage

// File: rtl/entity_physics_if.sv
// rtl/entity_physics_if.sv - per-entity control/collision inputs and packed state outputs
interface entity_physics_if
  import physics_pkg::*;
#(
  parameter int POS_W = 10,
  parameter int SPD_W = 5
);
  localparam int STATE_W = state_w(POS_W, SPD_W);

  logic               jump_r;
  logic               jump_held;
  logic [3:0]         col;
  logic [STATE_W-1:0] init_state;
  logic [STATE_W-1:0] entity_state;
  logic               airborne;
  logic [1:0]         phase;

  modport master (
    output jump_r, jump_held, col, init_state,
    input  entity_state, airborne, phase
  );

  modport slave (
    input  jump_r, jump_held, col, init_state,
    output entity_state, airborne, phase
  );
endinterface

// File: rtl/entity_physics_grid_snap.sv
// rtl/entity_physics_grid_snap.sv - pushes a colliding coordinate back to the tile boundary
module grid_snap #(
  parameter int W         = 10,
  parameter int TILE_LOG2 = 5,
  parameter int LOW_EXTRA = 0
) (
  input  logic [W-1:0] pos_nxt,
  input  logic [W-1:0] origin,
  input  logic         dir_hi,
  output logic [W-1:0] snapped
);
  localparam logic [W-1:0] TILE = W'(1 << TILE_LOG2);
  localparam logic [W-1:0] MASK = TILE - W'(1);
  localparam logic [W-1:0] BIAS = W'(LOW_EXTRA);

  logic [W-1:0] tile_off;

  assign tile_off = (pos_nxt - origin) & MASK;

  // Increasing-side hits land one pixel short of the tile; decreasing-side hits move into the next tile.
  assign snapped = dir_hi ? (pos_nxt - tile_off - W'(1))
                          : (pos_nxt + (TILE - tile_off - BIAS));
endmodule

// File: rtl/entity_physics.sv
// rtl/entity_physics.sv - per-entity kinematics FSM; optional ENTITY_PHYSICS_VARIABLE_JUMP_EN adds short hops
module entity_physics
  import physics_pkg::*;
#(
  parameter int POS_W     = 10,
  parameter int SPD_W     = 5,
  parameter int GRAVITY   = 1,
  parameter int JUMP_SPD  = 17,
  parameter int MAX_FALL  = 16,
  parameter int TILE_LOG2 = 5,
  parameter int ORG_X     = 144,
  parameter int ORG_Y     = 35,
  parameter int JUMP_BUF  = 4,
  parameter int CUT_SPD   = 4
) (
  input logic            sim_clk,
  input logic            reset_n,
  entity_physics_if.slave bus
);
  localparam int XS_OFF = off_xspd(SPD_W);
  localparam int Y_OFF  = off_y(SPD_W);
  localparam int X_OFF  = off_x(POS_W, SPD_W);
  localparam int JB_W   = (JUMP_BUF < 2) ? 1 : $clog2(JUMP_BUF + 1);
`ifdef ENTITY_PHYSICS_VARIABLE_JUMP_EN
  localparam logic VAR_JUMP = 1'b1;
`else
  localparam logic VAR_JUMP = 1'b0;
`endif

  logic [POS_W-1:0] x, y;
  logic [SPD_W-1:0] xspd, yspd;
  logic             xdir, ydir;
  phase_t           phase;
  logic             airborne_q;
  logic [JB_W-1:0]  jcnt;

  logic [POS_W-1:0] x_nxt, y_nxt, x_snap, y_snap;
  logic [SPD_W:0]   fall_sum;
  logic [SPD_W-1:0] fall_spd, rise_base;
  logic [JB_W-1:0]  jcnt_nxt;
  logic             hcol, pending;

  assign x_nxt = xdir ? (x + POS_W'(xspd)) : (x - POS_W'(xspd));
  assign y_nxt = ydir ? (y - POS_W'(yspd)) : (y + POS_W'(yspd));

  assign fall_sum = {1'b0, yspd} + (SPD_W+1)'(GRAVITY);
  assign fall_spd = (fall_sum > (SPD_W+1)'(MAX_FALL)) ? SPD_W'(MAX_FALL) : fall_sum[SPD_W-1:0];

  // Releasing the button mid-rise caps the speed before gravity is taken off.
  assign rise_base = (VAR_JUMP && !bus.jump_held && (yspd > SPD_W'(CUT_SPD))) ? SPD_W'(CUT_SPD) : yspd;

  assign hcol     = bus.col[COL_LEFT] | bus.col[COL_RIGHT];
  assign pending  = bus.jump_r | (jcnt != '0);
  assign jcnt_nxt = bus.jump_r ? JB_W'(JUMP_BUF) : ((jcnt != '0) ? (jcnt - JB_W'(1)) : '0);

  grid_snap #(.W(POS_W), .TILE_LOG2(TILE_LOG2), .LOW_EXTRA(0)) u_snap_x (
    .pos_nxt (x_nxt),
    .origin  (POS_W'(ORG_X)),
    .dir_hi  (xdir),
    .snapped (x_snap)
  );

  grid_snap #(.W(POS_W), .TILE_LOG2(TILE_LOG2), .LOW_EXTRA(1)) u_snap_y (
    .pos_nxt (y_nxt),
    .origin  (POS_W'(ORG_Y)),
    .dir_hi  (bus.col[COL_BOT]),
    .snapped (y_snap)
  );

  always_ff @(posedge sim_clk) begin
    if (!reset_n) begin
      x          <= bus.init_state[X_OFF +: POS_W];
      y          <= bus.init_state[Y_OFF +: POS_W];
      xspd       <= bus.init_state[XS_OFF +: SPD_W];
      yspd       <= bus.init_state[OFF_YSPD +: SPD_W];
      xdir       <= bus.init_state[OFF_XDIR];
      ydir       <= bus.init_state[OFF_YDIR];
      phase      <= PH_FALL;
      airborne_q <= 1'b1;
      jcnt       <= '0;
    end else begin
      x    <= hcol ? x_snap : x_nxt;
      xdir <= hcol ? ~xdir : xdir;
      y    <= y_nxt;
      jcnt <= jcnt_nxt;

      case (phase)
        PH_GROUND: begin
          if (pending) begin
            yspd       <= SPD_W'(JUMP_SPD);
            ydir       <= 1'b1;
            phase      <= PH_RISE;
            airborne_q <= 1'b1;
            jcnt       <= '0;
          end else begin
            yspd <= '0;
            if (!bus.col[COL_BOT]) begin
              phase      <= PH_FALL;
              airborne_q <= 1'b1;
            end
          end
        end
        PH_RISE: begin
          if (rise_base > SPD_W'(GRAVITY)) begin
            yspd <= rise_base - SPD_W'(GRAVITY);
          end else begin
            yspd  <= '0;
            ydir  <= 1'b0;
            phase <= PH_FALL;
          end
        end
        default: begin
          yspd <= fall_spd;
          ydir <= 1'b0;
        end
      endcase

      // Vertical collisions override the FSM, and so also override a same-tick jump.
      if (bus.col[COL_BOT] && (phase != PH_GROUND)) begin
        y          <= y_snap;
        yspd       <= '0;
        phase      <= PH_GROUND;
        airborne_q <= 1'b0;
      end else if (bus.col[COL_TOP] && !bus.col[COL_BOT]) begin
        y          <= y_snap;
        yspd       <= '0;
        ydir       <= 1'b0;
        phase      <= PH_FALL;
        airborne_q <= 1'b1;
      end
    end
  end

  assign bus.entity_state = {x, y, xspd, yspd, xdir, ydir};
  assign bus.phase        = phase;
  assign bus.airborne     = airborne_q;
endmodule

// File: tb/tb_entity_physics.sv
// tb/tb_entity_physics.sv - directed and randomized checks of entity_physics against an integer model
module tb_entity_physics;
  localparam int POS_W = 10;
  localparam int SPD_W = 5;

  int checks = 0;
  int errors = 0;

  logic sim_clk = 1'b0;
  logic reset_n;

  entity_physics_if #(.POS_W(POS_W), .SPD_W(SPD_W)) bus ();

  entity_physics dut (
    .sim_clk (sim_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 sim_clk = ~sim_clk;

  int mx, my, mxs, mys, mxd, myd, mph, mcnt;

  function automatic logic [31:0] pack(int x, int y, int xs, int ys, int xd, int yd);
    logic [31:0] v;
    v = {x[9:0], y[9:0], xs[4:0], ys[4:0], xd[0], yd[0]};
    return v;
  endfunction

  function automatic int wrap(int v);
    return ((v % 1024) + 1024) % 1024;
  endfunction

  function automatic int toff(int v, int org);
    return wrap(v - org) % 32;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sim_clk);
    #1;
  endtask

  task automatic do_reset(logic [31:0] init);
    bus.init_state = init;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mx = int'(init[31:22]); my = int'(init[21:12]);
    mxs = int'(init[11:7]); mys = int'(init[6:2]);
    mxd = int'(init[1]); myd = int'(init[0]);
    mph = 2; mcnt = 0;
  endtask

  task automatic model_step(logic jr, logic held, logic [3:0] c);
    int xn, yn, ncnt, ph0, o, s;
    logic pend;
    xn = wrap(mx + (mxd != 0 ? mxs : -mxs));
    yn = wrap(my + (myd != 0 ? -mys : mys));
    pend = jr || (mcnt > 0);
    ncnt = jr ? 4 : (mcnt > 0 ? mcnt - 1 : 0);
    ph0 = mph;
    if (c[0] || c[2]) begin
      o = toff(xn, 144);
      mx = (mxd != 0) ? wrap(xn - o - 1) : wrap(xn + 32 - o);
      mxd = 1 - mxd;
    end else begin
      mx = xn;
    end
    my = yn;
    case (ph0)
      0: begin
        if (pend) begin mys = 17; myd = 1; mph = 1; ncnt = 0; end
        else begin mys = 0; if (!c[1]) mph = 2; end
      end
      1: begin
        s = mys;
`ifdef ENTITY_PHYSICS_VARIABLE_JUMP_EN
        if (!held && s > 4) s = 4;
`endif
        if (s > 1) mys = s - 1;
        else begin mys = 0; myd = 0; mph = 2; end
      end
      default: begin
        mys = (mys + 1 > 16) ? 16 : mys + 1;
        myd = 0;
      end
    endcase
    if (c[1] && ph0 != 0) begin
      o = toff(yn, 35); my = wrap(yn - o - 1); mys = 0; mph = 0;
    end else if (c[3] && !c[1]) begin
      o = toff(yn, 35); my = wrap(yn + 32 - (o + 1)); mys = 0; myd = 0; mph = 2;
    end
    mcnt = ncnt;
    if (held === 1'bx) mcnt = mcnt;
  endtask

  initial begin
    logic [31:0] st;
    int vexp;
    reset_n = 1'b0;
    bus.jump_r = 1'b0;
    bus.jump_held = 1'b1;
    bus.col = 4'b0000;
    bus.init_state = '0;

    do_reset(pack(176, 99, 4, 0, 1, 0));
    chk("rst_state", bus.entity_state, pack(176, 99, 4, 0, 1, 0));
    chk("rst_phase", bus.phase, 2);
    chk("rst_airborne", bus.airborne, 1);
    tick();
    st = bus.entity_state;
    chk("t1_x", st[31:22], 180);
    chk("t1_y", st[21:12], 99);
    chk("t1_yspd", st[6:2], 1);
    chk("t1_phase", bus.phase, 2);

    do_reset(pack(300, 100, 0, 0, 1, 0));
    for (int t = 1; t <= 20; t++) begin
      tick();
      st = bus.entity_state;
      chk("term_yspd", st[6:2], (t < 16) ? t : 16);
    end

    do_reset(pack(200, 500, 4, 0, 1, 0));
    bus.col = 4'b0100;
    tick();
    st = bus.entity_state;
    chk("rwall_x", st[31:22], 175);
    chk("rwall_xdir", st[1], 0);
    bus.col = 4'b0000;

    do_reset(pack(300, 90, 0, 10, 1, 0));
    bus.col = 4'b0010;
    tick();
    st = bus.entity_state;
    chk("land_y", st[21:12], 98);
    chk("land_yspd", st[6:2], 0);
    chk("land_phase", bus.phase, 0);
    chk("land_airborne", bus.airborne, 0);
    bus.col = 4'b0000;

    do_reset(pack(300, 30, 0, 0, 1, 0));
    bus.jump_r = 1'b1;
    tick();
    bus.jump_r = 1'b0;
    tick();
    bus.col = 4'b0010;
    tick();
    chk("buf_land_phase", bus.phase, 0);
    tick();
    st = bus.entity_state;
    chk("buf_jump_yspd", st[6:2], 17);
    chk("buf_jump_ydir", st[0], 1);
    chk("buf_jump_phase", bus.phase, 1);

    bus.col = 4'b0000;
    repeat (5) tick();
    st = bus.entity_state;
    chk("rise_yspd12", st[6:2], 12);
    bus.jump_held = 1'b0;
    tick();
    st = bus.entity_state;
`ifdef ENTITY_PHYSICS_VARIABLE_JUMP_EN
    vexp = 3;
`else
    vexp = 11;
`endif
    chk("varjump_yspd", st[6:2], vexp);
    bus.jump_held = 1'b1;

    do_reset(pack(300, 30, 0, 0, 1, 0));
    bus.jump_r = 1'b1;
    tick();
    bus.jump_r = 1'b0;
    repeat (5) tick();
    bus.col = 4'b0010;
    tick();
    chk("stale_land_phase", bus.phase, 0);
    tick();
    st = bus.entity_state;
    chk("stale_nojump_phase", bus.phase, 0);
    chk("stale_nojump_yspd", st[6:2], 0);
    bus.col = 4'b0000;

    do_reset($urandom);
    for (int t = 0; t < 500; t++) begin
      logic [3:0] c;
      logic jr, hd;
      if ($urandom_range(0, 63) == 0) begin
        do_reset($urandom);
        chk("rnd_reset_state", bus.entity_state, pack(mx, my, mxs, mys, mxd, myd));
      end else begin
        c[0] = ($urandom_range(0, 11) == 0);
        c[1] = ($urandom_range(0, 3) == 0);
        c[2] = ($urandom_range(0, 11) == 0);
        c[3] = ($urandom_range(0, 15) == 0);
        jr = ($urandom_range(0, 5) == 0);
        hd = ($urandom_range(0, 1) == 1);
        bus.col = c;
        bus.jump_r = jr;
        bus.jump_held = hd;
        tick();
        model_step(jr, hd, c);
        chk("rnd_state", bus.entity_state, pack(mx, my, mxs, mys, mxd, myd));
        chk("rnd_phase", bus.phase, mph);
        chk("rnd_airborne", bus.airborne, (mph != 0) ? 1 : 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
